// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Register map, CFG/STAT bit positions and TX FSM states shared
//             by the UART host interface.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [7:0] c_ADDR_CPB  = 8'h00;
    localparam logic [7:0] c_ADDR_STP  = 8'h04;
    localparam logic [7:0] c_ADDR_RDR  = 8'h08;
    localparam logic [7:0] c_ADDR_TDR  = 8'h0C;
    localparam logic [7:0] c_ADDR_CFG  = 8'h10;
    localparam logic [7:0] c_ADDR_STAT = 8'h14;

    localparam int c_CFG_TX_EN   = 0;
    localparam int c_CFG_RX_EN   = 1;
    localparam int c_CFG_IRQ_RX  = 2;
    localparam int c_CFG_IRQ_TXE = 3;

    localparam int c_STAT_TX_FULL  = 0;
    localparam int c_STAT_TX_EMPTY = 1;
    localparam int c_STAT_RX_FULL  = 2;
    localparam int c_STAT_RX_EMPTY = 3;
    localparam int c_STAT_TX_BUSY  = 4;
    localparam int c_STAT_RX_OVF   = 5;
    localparam int c_STAT_TX_OVF   = 6;

    localparam logic [31:0] c_CPB_MIN = 32'd4;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_BUSY = 2'd1,
        T_GAP  = 2'd2
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync_fifo
//  Brief    : Single-clock first-word-fall-through FIFO; a pop frees room for
//             a push in the same cycle, so full+push+pop never drops data.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int                c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop & (r_level != '0);
    assign w_push = push & ((r_level != c_FULL) | w_pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; contents are only observable through the level.
    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_level == c_FULL);
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_host_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_host_if
//  Brief    : Register front end for the UART engine: CPB/STP/CFG/STAT
//             registers, TX/RX byte FIFOs, transmit sequencer and interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_host_if
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] DEFAULT_CPB = 32'd868
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        reg_wr_i,
    input  logic        reg_rd_i,
    input  logic [7:0]  reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic [31:0] reg_rdata_o,
    output logic [31:0] uart_cpb_reg_o,
    output logic [31:0] uart_stp_reg_o,
    output logic        data_tx_start_o,
    output logic [7:0]  uart_tx_data_o,
    input  logic        data_sent_i,
    input  logic        rx_received_i,
    input  logic [7:0]  rx_received_data_i,
    output logic        irq_o
);

    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]        r_cpb;
    logic [1:0]         r_stp;
    logic [3:0]         r_cfg;
    logic               r_rx_ovf;
    logic               r_tx_ovf;
    logic [31:0]        r_rdata;
    logic [7:0]         r_tx_data;
    tx_state_t          r_state;
    tx_state_t          w_state_nxt;

    logic               w_tx_pop, w_tx_full, w_tx_empty, w_tx_busy;
    logic               w_rx_push, w_rx_full, w_rx_empty;
    logic [7:0]         w_tx_dout, w_rx_dout;
    logic [c_LVL_W-1:0] w_tx_level, w_rx_level;
    logic               w_wr_tdr, w_wr_stat, w_rd_rdr;
    logic               w_rx_ovf_set, w_tx_ovf_set;
    logic [31:0]        w_stat;
    logic [31:0]        w_rdata;

    assign w_wr_tdr  = reg_wr_i & (reg_addr_i == c_ADDR_TDR);
    assign w_wr_stat = reg_wr_i & (reg_addr_i == c_ADDR_STAT);
    assign w_rd_rdr  = reg_rd_i & (reg_addr_i == c_ADDR_RDR);
    assign w_rx_push = rx_received_i & r_cfg[c_CFG_RX_EN];

    // A full FIFO only drops when no pop frees a slot in the same cycle.
    assign w_rx_ovf_set = w_rx_push & w_rx_full & ~w_rd_rdr;
    assign w_tx_ovf_set = w_wr_tdr & w_tx_full & ~w_tx_pop;

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (w_wr_tdr),
        .din     (reg_wdata_i[7:0]),
        .pop     (w_tx_pop),
        .dout    (w_tx_dout),
        .full    (w_tx_full),
        .empty   (w_tx_empty),
        .level   (w_tx_level)
    );

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (w_rx_push),
        .din     (rx_received_data_i),
        .pop     (w_rd_rdr),
        .dout    (w_rx_dout),
        .full    (w_rx_full),
        .empty   (w_rx_empty),
        .level   (w_rx_level)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        case (r_state)
            T_IDLE: begin
                if (r_cfg[c_CFG_TX_EN] && !w_tx_empty) begin
                    w_tx_pop    = 1'b1;
                    w_state_nxt = T_BUSY;
                end
            end
            T_BUSY:  if (data_sent_i) w_state_nxt = T_GAP;
            T_GAP:   w_state_nxt = T_IDLE;
            default: w_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= T_IDLE;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tx_pop) r_tx_data <= w_tx_dout;
        end
    end

    assign w_tx_busy = (r_state != T_IDLE);

    always_comb begin
        w_stat                  = '0;
        w_stat[c_STAT_TX_FULL]  = w_tx_full;
        w_stat[c_STAT_TX_EMPTY] = w_tx_empty;
        w_stat[c_STAT_RX_FULL]  = w_rx_full;
        w_stat[c_STAT_RX_EMPTY] = w_rx_empty;
        w_stat[c_STAT_TX_BUSY]  = w_tx_busy;
        w_stat[c_STAT_RX_OVF]   = r_rx_ovf;
        w_stat[c_STAT_TX_OVF]   = r_tx_ovf;
        w_stat[15:8]            = 8'(w_tx_level);
        w_stat[23:16]           = 8'(w_rx_level);
    end

    always_comb begin
        w_rdata = '0;
        case (reg_addr_i)
            c_ADDR_CPB:  w_rdata = r_cpb;
            c_ADDR_STP:  w_rdata = {30'd0, r_stp};
            c_ADDR_RDR:  w_rdata = w_rx_empty ? 32'd0 : {1'b1, 23'd0, w_rx_dout};
            c_ADDR_CFG:  w_rdata = {28'd0, r_cfg};
            c_ADDR_STAT: w_rdata = w_stat;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cpb    <= DEFAULT_CPB;
            r_stp    <= '0;
            r_cfg    <= '0;
            r_rx_ovf <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (reg_wr_i) begin
                case (reg_addr_i)
                    c_ADDR_CPB: r_cpb <= (reg_wdata_i < c_CPB_MIN) ? c_CPB_MIN : reg_wdata_i;
                    c_ADDR_STP: r_stp <= reg_wdata_i[1:0];
                    c_ADDR_CFG: r_cfg <= reg_wdata_i[3:0];
                    default:    ;
                endcase
            end
            // A new overflow in the clearing cycle wins over the clear.
            r_rx_ovf <= w_rx_ovf_set | (r_rx_ovf & ~(w_wr_stat & reg_wdata_i[c_STAT_RX_OVF]));
            r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~(w_wr_stat & reg_wdata_i[c_STAT_TX_OVF]));
            if (reg_rd_i) r_rdata <= w_rdata;
        end
    end

    assign reg_rdata_o     = r_rdata;
    assign uart_cpb_reg_o  = r_cpb;
    assign uart_stp_reg_o  = {30'd0, r_stp};
    assign data_tx_start_o = (r_state == T_BUSY);
    assign uart_tx_data_o  = r_tx_data;
    assign irq_o           = (r_cfg[c_CFG_IRQ_RX] & ~w_rx_empty)
                           | (r_cfg[c_CFG_IRQ_TXE] & w_tx_empty & ~w_tx_busy);

endmodule
`default_nettype wire
